// File: rtl/mod_reduce_seq_if.sv
// ----------------------------------------------------------------------------
// mod_reduce_seq_if
// Handshake/data bundle for the sequential modular reducer.
//   in_valid/in_ready : operand handshake (A, q presented together)
//   A                 : 2*DATA_W-bit value to reduce
//   q                 : DATA_W-bit modulus
//   out_valid/out_ready: result handshake
//   R                 : A mod q (0 when err)
//   err               : sampled modulus was zero
// master = producer/consumer around the reducer, slave = the reducer itself.
// ----------------------------------------------------------------------------
interface mod_reduce_seq_if #(
    parameter int DATA_W = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*DATA_W-1:0]   A;
    logic [DATA_W-1:0]     q;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     R;
    logic                  err;

    modport master (
        output in_valid, A, q, out_ready,
        input  in_ready, out_valid, R, err
    );

    modport slave (
        input  in_valid, A, q, out_ready,
        output in_ready, out_valid, R, err
    );
endinterface

// File: rtl/mod_reduce_seq.sv
// ----------------------------------------------------------------------------
// mod_reduce_seq
// Bit-serial restoring reducer: R = A mod q, one bit of A per cycle
// (2*DATA_W cycles per operation), MSB first.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mod_reduce_seq_if slave (in/out valid-ready handshakes, A, q, R, err)
// A zero modulus still runs the full 2*DATA_W steps so latency is uniform;
// the result is then forced to 0 and err is raised.
// ----------------------------------------------------------------------------
module mod_reduce_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mod_reduce_seq_if.slave   bus
);
    localparam int AW = 2 * DATA_W;
    localparam int CW = $clog2(AW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [AW-1:0]     a_lat;
    logic [DATA_W-1:0] q_lat;
    logic [DATA_W:0]   r;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] r_out;
    logic              err_q;

    // One restoring step. t is one bit wider than r so that q near 2^W-1
    // cannot wrap the comparison. When t >= q the difference is < q, so the
    // low W+1 bits of the subtraction are exact.
    logic [DATA_W+1:0] t;
    logic [DATA_W:0]   diff;
    logic [DATA_W:0]   r_next;

    always_comb begin
        t      = {r, a_lat[cnt]};
        diff   = t[DATA_W:0] - {1'b0, q_lat};
        r_next = (t >= {2'b00, q_lat}) ? diff : t[DATA_W:0];
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.R         = r_out;
    assign bus.err       = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            a_lat <= '0;
            q_lat <= '0;
            r     <= '0;
            cnt   <= '0;
            r_out <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_lat <= bus.A;
                        q_lat <= bus.q;
                        r     <= '0;
                        cnt   <= CW'(AW - 1);
                        err_q <= (bus.q == '0);
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r <= r_next;
                    if (cnt == '0) begin
                        r_out <= err_q ? '0 : r_next[DATA_W-1:0];
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mod_reduce_seq.md
Name: mod_reduce_seq

Overview:
- Sequential modular reducer; consumer side of the integer multiplier's 2W-bit product.
- Takes a 2W-bit operand A and a W-bit modulus q, and returns R = A mod q.
- Uses bit-serial restoring shift-subtract reduction, one operand bit per cycle, with valid/ready handshakes on both sides.
- Sits between the integer multiplier output and the NTT butterfly datapath.

Parameters:
DATA_W, 32, operand width W; A is 2W bits, q and R are W bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  A/q presented
in_ready  output  1  block can accept A/q
A  input  2*DATA_W  value to reduce (multiplier product)
q  input  DATA_W  modulus; sampled with A
out_valid  output  1  R/err valid
out_ready  input  1  downstream accepts R
R  output  DATA_W  A mod q
err  output  1  set with out_valid when sampled q was 0

Behaviour:
- Reset (async, active-high):
  - state=IDLE; in_ready=1; out_valid=0; R=0; err=0.
  - Internal remainder, bit counter, and latched A/q cleared to 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready (cycle T): latch A and q, remainder r=0, counter=2W-1, go to BUSY.
  - If sampled q==0: latch err=1 and go to BUSY anyway, so the timing is uniform.
- BUSY:
  - in_ready=0; in_valid is ignored and the A/q inputs are don't-care.
  - Each cycle: t = {r,A_lat[counter]} (W+2 bits); if t>=q_lat then r=t-q_lat, else r=t.
  - r is W+1 bits; the invariant r<q holds after every step.
  - After the step with counter==0, go to DONE; otherwise decrement the counter.
  - Exactly 2W BUSY cycles.
- DONE:
  - out_valid=1 from cycle T+2W+1.
  - R = r[W-1:0], or R=0 when err=1.
  - R and err stay stable while out_valid=1 && out_ready=0 (no limit on stall length).
  - On out_valid&&out_ready: go to IDLE; out_valid drops the next cycle.
  - R and err keep their last values until the next DONE.
- in_ready is 1 only in IDLE. There is no same-cycle accept on the output handshake, so minimum spacing between accepts is 2W+2 cycles.
- Edge cases:
  - q==1 gives R=0.
  - A<q gives R=A.
  - A=0 gives R=0.
  - q near 2^W-1 must not overflow, because t is W+2 bits wide.
- Reset asserted in BUSY or DONE aborts the in-flight operation immediately and returns all outputs to reset values. No partial result is ever flagged valid.
- err clears when the next operand is accepted.

Test Plan:
1. A=100, q=7, out_ready=1 -> out_valid first high exactly 65 cycles after the accept (DATA_W=32); R=2, err=0; in_ready low from T+1 until return to IDLE.
2. A=2^64-1, q=0xFFFFFFFB -> R=24; then A=12288, q=12289 -> R=12288 (A<q path); then A=12289*12289, q=12289 -> R=0.
3. A=2^64-1, q=0xFFFFFFFF -> R=0; A=2^64-2, q=0xFFFFFFFF -> R=0xFFFFFFFE; then q=1 with arbitrary A -> R=0. No overflow occurs.
4. Backpressure: A=100, q=7, out_ready held 0 for 10 cycles after out_valid rises -> R=2 and out_valid=1 stable throughout, in_ready=0, and in_valid pulses are ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
5. q=0, A=12345 -> out_valid after 65 cycles with err=1, R=0; next op A=10, q=3 -> err=0, R=1.
6. Reset pulsed asynchronously mid-BUSY (cycle T+20) -> out_valid=0, R=0, err=0, in_ready=1 immediately; a fresh op A=50, q=9 afterward -> R=5 with normal latency.
